// File: rtl/aap_dbg_reg_port_if.sv
// rtl/aap_dbg_reg_port_if.sv - host link byte channels and register-file debug port bundle
interface aap_dbg_reg_port_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [5:0]  dbg_reg_rregnum;
  logic [15:0] dbg_reg_rdata;
  logic [5:0]  dbg_reg_wregnum;
  logic [15:0] dbg_reg_wdata;
  logic        dbg_reg_we;

  modport master (
    input  rx_data, rx_valid, tx_ready, dbg_reg_rdata,
    output rx_ready, tx_data, tx_valid,
    output dbg_reg_rregnum, dbg_reg_wregnum, dbg_reg_wdata, dbg_reg_we
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, dbg_reg_rdata,
    input  rx_ready, tx_data, tx_valid,
    input  dbg_reg_rregnum, dbg_reg_wregnum, dbg_reg_wdata, dbg_reg_we
  );
endinterface

// File: rtl/aap_dbg_reg_port.sv
// rtl/aap_dbg_reg_port.sv - byte-command debug master for the register file debug port
module aap_dbg_reg_port #(
  parameter int         NUM_REGS     = 16,
  parameter int         TIMEOUT      = 65535,
  parameter logic [2:0] STATE_HALTED = 3'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  aap_dbg_reg_port_if.master bus
);
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;
  localparam int         TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, GET_REG, GET_HI, GET_LO, EXEC, SEND_ACK, SEND_HI, SEND_LO, SEND_NAK
  } fsm_e;

  fsm_e          fsm_q, fsm_d;
  logic          is_write_q, is_write_d;
  logic [5:0]    regnum_q, regnum_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic rx_ready, rx_fire, tx_fire, in_get, exec_ok;

  assign in_get   = (fsm_q == GET_REG) || (fsm_q == GET_HI) || (fsm_q == GET_LO);
  assign rx_ready = (fsm_q == IDLE) || in_get;
  assign rx_fire  = rx_ready && bus.rx_valid;
  assign tx_fire  = tx_valid_q && bus.tx_ready;
  assign exec_ok  = (state == STATE_HALTED) && ({26'd0, regnum_q} < NUM_REGS);

  always_comb begin
    fsm_d      = fsm_q;
    is_write_d = is_write_q;
    regnum_d   = regnum_q;
    wdata_d    = wdata_q;
    shadow_d   = shadow_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tmo_d      = tmo_q;
    case (fsm_q)
      IDLE: begin
        tmo_d = '0;
        if (rx_fire) begin
          if (bus.rx_data == OP_READ || bus.rx_data == OP_WRITE) begin
            is_write_d = (bus.rx_data == OP_WRITE);
            fsm_d      = GET_REG;
          end else begin
            fsm_d      = SEND_NAK;
            tx_valid_d = 1'b1;
            tx_data_d  = RSP_NAK;
          end
        end
      end
      GET_REG: if (rx_fire) begin
        regnum_d = bus.rx_data[5:0];
        fsm_d    = is_write_q ? GET_HI : EXEC;
      end
      GET_HI: if (rx_fire) begin
        wdata_d = {bus.rx_data, wdata_q[7:0]};
        fsm_d   = GET_LO;
      end
      GET_LO: if (rx_fire) begin
        wdata_d = {wdata_q[15:8], bus.rx_data};
        fsm_d   = EXEC;
      end
      EXEC: begin
        tx_valid_d = 1'b1;
        if (!exec_ok) begin
          fsm_d     = SEND_NAK;
          tx_data_d = RSP_NAK;
        end else begin
          fsm_d     = SEND_ACK;
          tx_data_d = RSP_ACK;
          if (!is_write_q) shadow_d = bus.dbg_reg_rdata;
        end
      end
      SEND_ACK: if (tx_fire) begin
        if (is_write_q) begin
          fsm_d      = IDLE;
          tx_valid_d = 1'b0;
        end else begin
          fsm_d     = SEND_HI;
          tx_data_d = shadow_q[15:8];
        end
      end
      SEND_HI: if (tx_fire) begin
        fsm_d     = SEND_LO;
        tx_data_d = shadow_q[7:0];
      end
      SEND_LO, SEND_NAK: if (tx_fire) begin
        fsm_d      = IDLE;
        tx_valid_d = 1'b0;
      end
      default: fsm_d = IDLE;
    endcase

    // Inter-byte timeout: any accepted byte restarts the window.
    if (in_get) begin
      if (rx_fire) begin
        tmo_d = '0;
      end else if (TIMEOUT != 0 && tmo_q == TMO_LAST) begin
        fsm_d = IDLE;
        tmo_d = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= IDLE;
      is_write_q <= 1'b0;
      regnum_q   <= '0;
      wdata_q    <= '0;
      shadow_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tmo_q      <= '0;
    end else begin
      fsm_q      <= fsm_d;
      is_write_q <= is_write_d;
      regnum_q   <= regnum_d;
      wdata_q    <= wdata_d;
      shadow_q   <= shadow_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.rx_ready        = rx_ready;
  assign bus.tx_data         = tx_data_q;
  assign bus.tx_valid        = tx_valid_q;
  assign bus.dbg_reg_rregnum = regnum_q;
  assign bus.dbg_reg_wregnum = regnum_q;
  assign bus.dbg_reg_wdata   = wdata_q;
  // The strobe lives only in the EXEC cycle, so it is a decode of the state register.
  assign bus.dbg_reg_we      = (fsm_q == EXEC) && is_write_q && exec_ok;
endmodule

// File: tb/tb_aap_dbg_reg_port.sv
// tb/tb_aap_dbg_reg_port.sv - scoreboard bench for aap_dbg_reg_port
module tb_aap_dbg_reg_port;
  localparam logic [2:0] HALTED  = 3'd2;
  localparam logic [2:0] RUNNING = 3'd0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] state;

  aap_dbg_reg_port_if bus();

  aap_dbg_reg_port #(.NUM_REGS(16), .TIMEOUT(8), .STATE_HALTED(HALTED)) dut (
    .clk(clk), .rst(rst), .state(state), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [15:0] rf [16];
  logic [15:0] exp_rf [16];
  assign bus.dbg_reg_rdata = (bus.dbg_reg_rregnum < 6'd16) ? rf[bus.dbg_reg_rregnum[3:0]] : 16'hDEAD;
  always @(posedge clk)
    if (bus.dbg_reg_we && bus.dbg_reg_wregnum < 6'd16) rf[bus.dbg_reg_wregnum[3:0]] = bus.dbg_reg_wdata;

  int checks = 0;
  int errors = 0;
  logic [7:0]  txq [$];
  logic [21:0] wq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted tx byte and every write strobe must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tx_valid && bus.tx_ready) begin
        if (txq.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected actual=%0h required=none", bus.tx_data);
        end else chk("tx_byte", {24'd0, bus.tx_data}, {24'd0, txq.pop_front()});
      end
      if (bus.dbg_reg_we) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL we_unexpected actual=%0h:%0h required=none", bus.dbg_reg_wregnum, bus.dbg_reg_wdata);
        end else chk("write", {10'd0, bus.dbg_reg_wregnum, bus.dbg_reg_wdata}, {10'd0, wq.pop_front()});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (!bus.rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("rx_accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((txq.size() != 0 || wq.size() != 0 || bus.tx_valid || !bus.rx_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_time", {31'd0, n < 500}, 32'd1);
  endtask

  task automatic do_write(input logic [7:0] r, input logic [15:0] d, input bit ok);
    txq.push_back(ok ? 8'h06 : 8'h15);
    if (ok) begin
      wq.push_back({r[5:0], d});
      exp_rf[r[3:0]] = d;
    end
    send_byte(8'h57); send_byte(r); send_byte(d[15:8]); send_byte(d[7:0]);
    wait_done();
  endtask

  task automatic do_read(input logic [7:0] r, input bit ok);
    logic [15:0] v;
    v = exp_rf[r[3:0]];
    if (ok) begin
      txq.push_back(8'h06); txq.push_back(v[15:8]); txq.push_back(v[7:0]);
    end else txq.push_back(8'h15);
    send_byte(8'h52); send_byte(r);
    wait_done();
  endtask

  task automatic check_reset_values();
    chk("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    chk("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    chk("rst_we", {31'd0, bus.dbg_reg_we}, 32'd0);
    chk("rst_rregnum", {26'd0, bus.dbg_reg_rregnum}, 32'd0);
    chk("rst_wregnum", {26'd0, bus.dbg_reg_wregnum}, 32'd0);
    chk("rst_wdata", {16'd0, bus.dbg_reg_wdata}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) begin
      rf[i]     = 16'h1000 + 16'(i);
      exp_rf[i] = 16'h1000 + 16'(i);
    end
    state        = HALTED;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b0;

    // Halted write then read-back.
    do_write(8'h05, 16'h1234, 1'b1);
    do_read(8'h05, 1'b1);

    // Not halted: both rejected, no write strobe.
    state = RUNNING;
    do_write(8'h03, 16'hABCD, 1'b0);
    do_read(8'h03, 1'b0);
    state = HALTED;

    // Out-of-range regnum, bad opcode, then normal traffic.
    do_read(8'h10, 1'b0);
    txq.push_back(8'h15);
    send_byte(8'h41);
    wait_done();
    do_read(8'h05, 1'b1);
    do_read(8'h0F, 1'b1);
    do_read(8'h45, 1'b1);

    // Backpressure while the high data byte is presented.
    bus.tx_ready = 1'b0;
    txq.push_back(8'h06); txq.push_back(8'h12); txq.push_back(8'h34);
    send_byte(8'h52); send_byte(8'h05);
    n = 0;
    while (!bus.tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ack_presented", {31'd0, bus.tx_valid}, 32'd1);
    @(posedge clk); #1 bus.tx_ready = 1'b1;
    @(posedge clk); #1 bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_tx_valid", {31'd0, bus.tx_valid}, 32'd1);
      chk("bp_tx_data", {24'd0, bus.tx_data}, 32'h12);
      chk("bp_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    end
    @(posedge clk); #1 bus.tx_ready = 1'b1;
    @(negedge clk);
    chk("bp_rx_ready_lo", {31'd0, bus.rx_ready}, 32'd0);
    wait_done();

    // Seven idle cycles between bytes is still within the window.
    txq.push_back(8'h06);
    wq.push_back({6'd2, 16'hBEEF});
    exp_rf[2] = 16'hBEEF;
    send_byte(8'h57); send_byte(8'h02); send_byte(8'hBE);
    repeat (7) @(posedge clk);
    send_byte(8'hEF);
    wait_done();

    // Eight idle cycles aborts the command silently.
    send_byte(8'h57); send_byte(8'h02);
    repeat (8) @(posedge clk);
    do_read(8'h02, 1'b1);

    // Reset in the middle of a write.
    send_byte(8'h57); send_byte(8'h06); send_byte(8'h11);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values();
    @(negedge clk);
    rst = 1'b0;
    do_read(8'h06, 1'b1);
    do_write(8'h06, 16'h5A5A, 1'b1);
    do_read(8'h06, 1'b1);

    repeat (4) @(negedge clk);
    chk("txq_empty", 32'(txq.size()), 32'd0);
    chk("wq_empty", 32'(wq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
